// File: rtl/lsu_mem_master_if.sv
// Request/response and memory-port bundle between the execute stage, the
// load/store unit and the word-addressed data memory.
interface lsu_mem_master_if #(
  parameter int ADDR_W = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one byte/half/word access per request, sub-word stores
// done as read-modify-write, misaligned/illegal requests answered without touching memory.
module lsu_mem_master #(
  parameter int ADDR_W = 8
) (
  input logic               clk,
  input logic               rst,
  lsu_mem_master_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic req_illegal(input logic we, input logic [2:0] f3, input logic [1:0] lo);
    logic bad_f3;
    logic misal;
    bad_f3 = 1'b1;
    misal  = 1'b0;
    case (f3)
      F3_B: begin
        bad_f3 = 1'b0;
        misal  = 1'b0;
      end
      F3_H: begin
        bad_f3 = 1'b0;
        misal  = lo[0];
      end
      F3_W: begin
        bad_f3 = 1'b0;
        misal  = (lo != 2'b00);
      end
      F3_BU: begin
        bad_f3 = we;
        misal  = 1'b0;
      end
      F3_HU: begin
        bad_f3 = we;
        misal  = lo[0];
      end
      default: begin
        bad_f3 = 1'b1;
        misal  = 1'b0;
      end
    endcase
    return bad_f3 | misal;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = 8'h00;
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_W:    r = word;
      F3_BU:   r = {24'h000000, b};
      F3_HU:   r = {16'h0000, h};
      default: r = 32'h00000000;
    endcase
    return r;
  endfunction

  // Replaces the addressed byte/half of the old word; a full-word store takes the data as-is.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [2:0] f3, input logic [1:0] lane);
    logic [31:0] r;
    r = old;
    case (f3)
      F3_B: begin
        case (lane)
          2'b00:   r[7:0]   = wd[7:0];
          2'b01:   r[15:8]  = wd[7:0];
          2'b10:   r[23:16] = wd[7:0];
          2'b11:   r[31:24] = wd[7:0];
          default: r        = old;
        endcase
      end
      F3_H: begin
        if (lane[1]) begin
          r[31:16] = wd[15:0];
        end else begin
          r[15:0] = wd[15:0];
        end
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  state_t            state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [1:0]        lane_r;
  logic [2:0]        funct3_r;
  logic              we_r;
  logic [31:0]       wdata_r;
  logic [31:0]       rd_buf_r;
  logic              mem_we_r;
  logic              resp_valid_r;
  logic [31:0]       resp_rdata_r;
  logic              resp_err_r;

  logic accept_s;
  logic req_err_s;
  logic unused_addr_s;

  assign accept_s      = bus.req_valid & bus.req_ready;
  assign req_err_s     = req_illegal(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
  assign unused_addr_s = ^bus.req_addr[31:ADDR_W+2];

  // Request sequencing FSM with all response/memory controls registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      addr_r       <= '0;
      lane_r       <= 2'b00;
      funct3_r     <= 3'b000;
      we_r         <= 1'b0;
      wdata_r      <= 32'h00000000;
      rd_buf_r     <= 32'h00000000;
      mem_we_r     <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'h00000000;
      resp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          resp_valid_r <= 1'b0;
          resp_rdata_r <= 32'h00000000;
          resp_err_r   <= 1'b0;
          mem_we_r     <= 1'b0;
          if (accept_s) begin
            addr_r   <= bus.req_addr[ADDR_W+1:2];
            lane_r   <= bus.req_addr[1:0];
            funct3_r <= bus.req_funct3;
            we_r     <= bus.req_we;
            wdata_r  <= bus.req_wdata;
            if (req_err_s) begin
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
            end else if (bus.req_we && (bus.req_funct3 == F3_W)) begin
              state_r  <= WRITE;
              mem_we_r <= 1'b1;
            end else begin
              state_r <= READ;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        READ: begin
          rd_buf_r <= bus.mem_rdata;
          if (we_r) begin
            state_r  <= WRITE;
            mem_we_r <= 1'b1;
          end else begin
            state_r      <= RESP;
            resp_valid_r <= 1'b1;
            resp_rdata_r <= load_extract(bus.mem_rdata, funct3_r, lane_r);
            resp_err_r   <= 1'b0;
          end
        end
        WRITE: begin
          mem_we_r     <= 1'b0;
          state_r      <= RESP;
          resp_valid_r <= 1'b1;
          resp_rdata_r <= 32'h00000000;
          resp_err_r   <= 1'b0;
        end
        RESP: begin
          resp_valid_r <= 1'b0;
          resp_rdata_r <= 32'h00000000;
          resp_err_r   <= 1'b0;
          mem_we_r     <= 1'b0;
          state_r      <= IDLE;
        end
        default: begin
          state_r      <= IDLE;
          mem_we_r     <= 1'b0;
          resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Reset gates the strobe combinationally so a reset landing in WRITE never commits.
  assign bus.req_ready  = (state_r == IDLE) & ~rst;
  assign bus.mem_we     = mem_we_r & ~rst;
  assign bus.mem_addr   = addr_r;
  assign bus.mem_wdata  = store_merge(rd_buf_r, wdata_r, funct3_r, lane_r);
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_err   = resp_err_r;

endmodule
